// File: rtl/tc_pl_bus_tx_sched.sv
// Round-robin scheduler for a shared transmit bus: grants one requester, sequences
// the chip-select stage and then the data stage, with a per-phase timeout.
module tc_pl_bus_tx_sched #(
    parameter int REQ_NUM = 4,
    parameter int TMO_W   = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [REQ_NUM-1:0] req,
    output logic [REQ_NUM-1:0] gnt,
    output logic [REQ_NUM-1:0] done,
    output logic               err,
    output logic               busy,
    output logic               csn_en,
    input  logic               csn_cmpt,
    output logic               dat_en,
    input  logic               dat_cmpt,
    input  logic [TMO_W-1:0]   tmo_cfg
);

    localparam int IW = (REQ_NUM > 2) ? $clog2(REQ_NUM) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CSN  = 2'd1,
        S_DAT  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t           state;
    logic [IW-1:0]    last;
    logic [IW-1:0]    win;
    logic [IW-1:0]    pick;
    logic [IW-1:0]    cand;
    logic             found;
    logic [TMO_W-1:0] cnt;
    logic [TMO_W-1:0] cnt_inc;
    logic             tmo_hit;

    // Search starts one past the previous winner and wraps.
    always_comb begin
        pick  = last;
        cand  = '0;
        found = 1'b0;
        for (int k = 1; k <= REQ_NUM; k++) begin
            cand = IW'((int'(last) + k) % REQ_NUM);
            if (!found && req[cand]) begin
                pick  = cand;
                found = 1'b1;
            end
        end
    end

    // Compare is live against tmo_cfg so a mid-phase change applies at once.
    assign tmo_hit = (tmo_cfg != '0) && (cnt == tmo_cfg - TMO_W'(1));
    assign cnt_inc = (cnt == '1) ? cnt : cnt + TMO_W'(1);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state  <= S_IDLE;
            gnt    <= '0;
            done   <= '0;
            err    <= 1'b0;
            busy   <= 1'b0;
            csn_en <= 1'b0;
            dat_en <= 1'b0;
            cnt    <= '0;
            last   <= IW'(REQ_NUM - 1);
            win    <= IW'(REQ_NUM - 1);
        end else begin
            done <= '0;
            err  <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (req != '0) begin
                        win    <= pick;
                        gnt    <= REQ_NUM'(1) << pick;
                        csn_en <= 1'b1;
                        busy   <= 1'b1;
                        cnt    <= '0;
                        state  <= S_CSN;
                    end
                end
                S_CSN: begin
                    if (csn_cmpt) begin
                        dat_en <= 1'b1;
                        cnt    <= '0;
                        state  <= S_DAT;
                    end else if (tmo_hit) begin
                        done   <= gnt;
                        err    <= 1'b1;
                        gnt    <= '0;
                        csn_en <= 1'b0;
                        dat_en <= 1'b0;
                        state  <= S_DONE;
                    end else begin
                        cnt <= cnt_inc;
                    end
                end
                S_DAT: begin
                    if (dat_cmpt || tmo_hit) begin
                        done   <= gnt;
                        err    <= !dat_cmpt;
                        gnt    <= '0;
                        csn_en <= 1'b0;
                        dat_en <= 1'b0;
                        state  <= S_DONE;
                    end else begin
                        cnt <= cnt_inc;
                    end
                end
                S_DONE: begin
                    last  <= win;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    gnt    <= '0;
                    csn_en <= 1'b0;
                    dat_en <= 1'b0;
                    busy   <= 1'b1;
                    state  <= S_DONE;
                end
            endcase
        end
    end

endmodule

// File: doc/tc_pl_bus_tx_sched.md
TC_PL_BUS_TX_SCHED -- requirements
Module: Tc_PL_bus_tx_sched

Interface
REQ-001 Parameter REQ_NUM, default 4: number of requesters sharing the transmit bus, range 2..8.
REQ-002 Parameter TMO_W, default 16: width of the phase timeout counter and of tmo_cfg.
REQ-003 clk  in  1  single clock; all logic SHALL be on its rising edge.
REQ-004 rst  in  1  reset, synchronous and active-low.
REQ-005 req  in  REQ_NUM  per-requester transmit request, level.
REQ-006 gnt  out  REQ_NUM  one-hot grant, held for the whole transfer.
REQ-007 done  out  REQ_NUM  one-cycle completion pulse to the granted requester.
REQ-008 err  out  1  one-cycle pulse, coincident with done, when the transfer ended by timeout.
REQ-009 busy  out  1  high whenever the state is not S_IDLE.
REQ-010 csn_en  out  1  enable to the chip-select stage; low clears that stage.
REQ-011 csn_cmpt  in  1  chip-select stage complete, sticky while csn_en is high.
REQ-012 dat_en  out  1  enable to the data stage.
REQ-013 dat_cmpt  in  1  data stage complete.
REQ-014 tmo_cfg  in  TMO_W  per-phase timeout in cycles; 0 disables the timeout.

Function
REQ-015 All outputs SHALL be registered, and each SHALL change on the clock edge that enters the state that defines it.
REQ-016 The FSM SHALL have the states S_IDLE, S_CSN, S_DAT and S_DONE; any other encoding SHALL go to S_DONE.
REQ-017 In S_IDLE with req != 0, the block SHALL pick a winner round-robin, latch it into gnt, set csn_en=1 and enter S_CSN; with req == 0 it SHALL stay in S_IDLE.
REQ-018 Round-robin priority SHALL start at index (last_granted+1) mod REQ_NUM and ascend with wrap; last_granted SHALL reset to REQ_NUM-1, so req[0] has highest priority after reset.
REQ-019 In S_CSN, csn_cmpt=1 SHALL move the FSM to S_DAT with dat_en=1 and csn_en held at 1, because the select must stay valid through the data phase.
REQ-020 In S_DAT, dat_cmpt=1 SHALL move the FSM to S_DONE.
REQ-021 In S_DONE: csn_en=0, dat_en=0, gnt=0, done[winner]=1 for exactly one cycle, last_granted updated to the winner, and the FSM SHALL return to S_IDLE on the next edge.
REQ-022 Because of REQ-021, csn_en SHALL be low for at least 2 cycles (S_DONE and S_IDLE) between transfers.
REQ-023 The timeout counter SHALL clear on every entry to S_CSN and S_DAT and increment by 1 each cycle spent in those states.
REQ-024 If tmo_cfg != 0 and the counter equals tmo_cfg-1 without the phase-complete input, the FSM SHALL go to S_DONE, and err SHALL pulse with done.
REQ-025 If the complete input and the timeout condition occur in the same cycle, the complete input SHALL win: no err, normal transition.
REQ-026 The counter SHALL saturate at all-ones, never wrapping.
REQ-027 Deasserting req[winner] mid-transfer SHALL be ignored; the transfer runs to completion or timeout.
REQ-028 req changes during S_CSN, S_DAT or S_DONE SHALL be sampled only in S_IDLE.
REQ-029 gnt SHALL never have more than one bit set; done and err SHALL never assert outside S_DONE.
REQ-030 A change of tmo_cfg mid-phase SHALL take effect immediately against the current count.

Reset
REQ-031 rst=0 at a clock edge SHALL force S_IDLE, gnt=0, done=0, err=0, busy=0, csn_en=0, dat_en=0, counter=0 and last_granted=REQ_NUM-1.
REQ-032 Reset SHALL take priority over every transition, including reset asserted mid-transfer; no done pulse SHALL be issued for an aborted transfer.
REQ-033 The first edge with rst=1 and req != 0 SHALL start arbitration per REQ-017.

Verification
REQ-034 After reset, req=4'b1111 with csn_cmpt and dat_cmpt each returned 3 cycles after their enable -> gnt sequence 0001, 0010, 0100, 1000, 0001; one done pulse per grant; csn_en low for at least 2 cycles between grants.
REQ-035 tmo_cfg=5, req=4'b0100, csn_cmpt never asserted -> S_CSN lasts 5 cycles; done=4'b0100 and err=1 together for 1 cycle; dat_en never high.
REQ-036 tmo_cfg=4, csn_cmpt asserted in the same cycle the count reaches 3 -> S_DAT entered, err=0.
REQ-037 tmo_cfg=0, dat_cmpt withheld for 70000 cycles -> no timeout; counter held at 16'hFFFF; transfer completes when dat_cmpt=1.
REQ-038 rst=0 asserted during S_DAT -> next cycle all outputs 0, no done; after release with req=4'b0010, gnt=4'b0010.
REQ-039 req[1] dropped in S_CSN after being granted -> transfer completes and done[1] pulses.
